// File: rtl/data_pipe_arb_interconnect.sv
// N-to-1 valid/ready pipe: commanded path (MODE 0) or round-robin (MODE 1), packet-locked grant.
// Ports: clock/rst_n/clk_en, vld_sw/sw -> curr_path/path_lock, s_* upstream, m_* downstream, beat_cnt.
module data_pipe_arb_interconnect #(
  parameter int DSIZE = 8,
  parameter int NUM   = 8,
  parameter int MODE  = 0,
  parameter int PW    = $clog2(NUM)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 vld_sw,
  input  logic [PW-1:0]        sw,
  output logic [PW-1:0]        curr_path,
  output logic                 path_lock,
  input  logic [NUM-1:0]       s_valid,
  input  logic [NUM-1:0]       s_last,
  input  logic [NUM*DSIZE-1:0] s_data,
  output logic [NUM-1:0]       s_ready,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [DSIZE-1:0]     m_data,
  input  logic                 m_ready,
  output logic [15:0]          beat_cnt
);

  logic             skid_vld;
  logic             skid_last;
  logic [DSIZE-1:0] skid_data;
  logic             granted;
  logic             done;
  logic             cnt_clr;
  logic             sel_valid;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             grant_vld;
  logic             accept;
  logic             xfer;
  logic             upd_ok;
  logic             rr_hit;
  logic [PW-1:0]    rr_idx;

  // Search starts past curr_path only once it has finished a packet;
  // straight out of reset channel 0 gets the first look.
  function automatic logic [PW-1:0] rr_pos(
    input logic [PW-1:0] base,
    input logic          skip,
    input int            k
  );
    int j;
    j = int'(base) + int'(skip) + k;
    if (j >= NUM) j = j - NUM;
    return PW'(j);
  endfunction

  always_comb begin
    sel_valid = s_valid[curr_path];
    sel_last  = s_last[curr_path];
    sel_data  = s_data[curr_path*DSIZE +: DSIZE];
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = curr_path;
    for (int k = 0; k < NUM; k++) begin
      if (!rr_hit && s_valid[rr_pos(curr_path, done, k)]) begin
        rr_hit = 1'b1;
        rr_idx = rr_pos(curr_path, done, k);
      end
    end
  end

  // A pending path change (sw != curr_path) blocks the old channel,
  // so no beat slips through in the cycle the path moves.
  always_comb begin
    if (MODE == 0)
      grant_vld = path_lock | (vld_sw & (sw == curr_path));
    else
      grant_vld = path_lock | (granted & sel_valid);
  end

  assign s_ready = (grant_vld & ~skid_vld & clk_en)
                 ? (NUM'(1) << curr_path) : '0;
  assign accept  = sel_valid & s_ready[curr_path];
  assign xfer    = m_valid & m_ready & clk_en;
  assign upd_ok  = clk_en & ~path_lock & ~skid_vld;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      skid_vld  <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
    end else if (!m_valid) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= sel_data;
        m_last  <= sel_last;
      end
    end else if (!skid_vld) begin
      if (accept && xfer) begin
        m_data <= sel_data;
        m_last <= sel_last;
      end else if (accept) begin
        skid_vld  <= 1'b1;
        skid_data <= sel_data;
        skid_last <= sel_last;
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
    end else if (xfer) begin
      m_data   <= skid_data;
      m_last   <= skid_last;
      skid_vld <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      curr_path <= '0;
      path_lock <= 1'b0;
      beat_cnt  <= '0;
      cnt_clr   <= 1'b0;
      granted   <= 1'b0;
      done      <= 1'b0;
    end else if (clk_en) begin
      if (accept) begin
        path_lock <= ~sel_last;
        beat_cnt  <= cnt_clr ? 16'd1 : beat_cnt + 16'd1;
        granted   <= 1'b0;
        done      <= sel_last;
      end else if (cnt_clr) begin
        beat_cnt <= '0;
      end
      cnt_clr <= accept & sel_last;
      if (upd_ok) begin
        if (MODE == 0) begin
          if (vld_sw) curr_path <= sw;
        end else if (!(granted && sel_valid)) begin
          granted <= rr_hit;
          if (rr_hit) begin
            curr_path <= rr_idx;
            done      <= 1'b0;
          end
        end
      end
    end
  end

endmodule
